// File: rtl/hdmi_video_pkg.sv
// Shared video-path definitions: edge-handling modes, default pixel width and
// the rotating line-bank index helper used by the line-window taps.
package hdmi_video_pkg;

  localparam int PIX_WIDTH_DEF  = 24;
  localparam int EDGE_ZERO      = 0;
  localparam int EDGE_REPLICATE = 1;

  // Bank holding the line k rows above the one being written into wr_bank.
  function automatic int tap_bank(input int wr_bank, input int k, input int num_banks);
    int r;
    r = (wr_bank - k) % num_banks;
    if (r < 0) r = r + num_banks;
    return r;
  endfunction

endpackage

// File: rtl/hdmi_line_ram.sv
// One stored video line: simple dual-port RAM, 1-cycle registered read, read-before-write
// on an address collision. No flow control; a read and a write may occur every cycle.
module hdmi_line_ram #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are never reset; the line window masks unfilled history instead.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: rtl/hdmi_line_window.sv
// Vertical NUM_TAPS-pixel column per input pixel from rotating line RAMs; 1-cycle latency,
// no backpressure (one pixel per cycle), pixels past MAX_LINE are dropped and flagged.
module hdmi_line_window
  import hdmi_video_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_WIDTH_DEF,
  parameter int MAX_LINE   = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_TAPS   = 3,
  parameter int EDGE_MODE  = EDGE_ZERO
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           in_sof,
  input  logic                           in_eol,
  output logic                           out_valid,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] out_taps,
  output logic [ADDR_WIDTH-1:0]          out_col,
  output logic                           out_eol,
  output logic                           out_full,
  output logic                           ovf_err
);

  localparam int NUM_BANKS = NUM_TAPS - 1;
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int LF_W      = $clog2(NUM_TAPS);
  localparam int COL_W     = ADDR_WIDTH + 1;

  localparam logic [COL_W-1:0]  COL_LIMIT = COL_W'(MAX_LINE);
  localparam logic [LF_W-1:0]   LF_MAX    = LF_W'(NUM_BANKS);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANKS - 1);

  typedef struct packed {
    logic                  eol;
    logic                  full;
    logic [ADDR_WIDTH-1:0] col;
  } meta_t;

  // Line-tracking state; col needs one extra bit to sit at MAX_LINE while overflowing.
  logic [COL_W-1:0]  col_q;
  logic [BANK_W-1:0] wr_bank_q;
  logic [LF_W-1:0]   lf_q;

  logic [COL_W-1:0]  col_eff;
  logic [BANK_W-1:0] bank_eff;
  logic [LF_W-1:0]   lf_eff;
  logic              accept;
  logic              drop;

  // State sampled with the pixel, used one cycle later when RAM data arrives.
  logic                  valid_q;
  logic                  ovf_q;
  logic [DATA_WIDTH-1:0] tap0_q;
  meta_t                 meta_q;
  logic [BANK_W-1:0]     bank_s_q;
  logic [LF_W-1:0]       lf_s_q;

  logic [DATA_WIDTH-1:0]          ram_q [NUM_BANKS];
  logic [NUM_TAPS*DATA_WIDTH-1:0] taps_c;

  // A start-of-frame acts before the pixel it arrives with.
  always_comb begin
    col_eff  = col_q;
    bank_eff = wr_bank_q;
    lf_eff   = lf_q;
    if (in_valid && in_sof) begin
      col_eff  = '0;
      bank_eff = '0;
      lf_eff   = '0;
    end
  end

  assign accept = in_valid && (col_eff < COL_LIMIT);
  assign drop   = in_valid && !accept;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    hdmi_line_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MAX_LINE),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk     (clk),
      .wr_en   (accept && (bank_eff == BANK_W'(b))),
      .wr_addr (col_eff[ADDR_WIDTH-1:0]),
      .wr_data (in_data),
      .rd_en   (accept),
      .rd_addr (col_eff[ADDR_WIDTH-1:0]),
      .rd_data (ram_q[b])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q     <= '0;
      wr_bank_q <= '0;
      lf_q      <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      tap0_q    <= '0;
      meta_q    <= '0;
      bank_s_q  <= '0;
      lf_s_q    <= '0;
    end else begin
      valid_q <= accept;
      ovf_q   <= drop;
      if (accept) begin
        tap0_q   <= in_data;
        meta_q   <= '{eol: in_eol, full: (lf_eff == LF_MAX), col: col_eff[ADDR_WIDTH-1:0]};
        bank_s_q <= bank_eff;
        lf_s_q   <= lf_eff;
      end
      if (in_valid) begin
        if (in_eol) begin
          // End of line closes the line even when its last pixel was dropped.
          col_q     <= '0;
          wr_bank_q <= (bank_eff == BANK_LAST) ? '0 : bank_eff + 1'b1;
          lf_q      <= (lf_eff == LF_MAX) ? lf_eff : lf_eff + 1'b1;
        end else begin
          col_q     <= accept ? col_eff + 1'b1 : col_eff;
          wr_bank_q <= bank_eff;
          lf_q      <= lf_eff;
        end
      end
    end
  end

  // Taps above the filled history are zeroed or copied from the oldest valid line.
  always_comb begin
    taps_c = '0;
    taps_c[0 +: DATA_WIDTH] = tap0_q;
    for (int k = 1; k < NUM_TAPS; k++) begin
      if (k <= int'(lf_s_q)) begin
        taps_c[k*DATA_WIDTH +: DATA_WIDTH] =
          ram_q[BANK_W'(tap_bank(int'(bank_s_q), k, NUM_BANKS))];
      end else if (EDGE_MODE == EDGE_REPLICATE) begin
        if (lf_s_q == '0) begin
          taps_c[k*DATA_WIDTH +: DATA_WIDTH] = tap0_q;
        end else begin
          taps_c[k*DATA_WIDTH +: DATA_WIDTH] =
            ram_q[BANK_W'(tap_bank(int'(bank_s_q), int'(lf_s_q), NUM_BANKS))];
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_taps  = taps_c;
  assign out_col   = meta_q.col;
  assign out_eol   = meta_q.eol;
  assign out_full  = meta_q.full;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_hdmi_line_window.sv
// Line-window bench: a zero-fill and a replicate instance share one stimulus stream and are
// compared against a line-history model, a directed vector table and hand-written sequences.
module tb_hdmi_line_window;

  localparam int DW = 8;
  localparam int ML = 8;
  localparam int AW = 3;
  localparam int NT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_sof, in_eol;
  logic [DW-1:0] in_data;

  logic            vz, ez, fz, oz, vr, er, fr, or_;
  logic [NT*DW-1:0] tz, tr;
  logic [AW-1:0]    cz, cr;

  always #5 clk = ~clk;

  hdmi_line_window #(.DATA_WIDTH(DW), .MAX_LINE(ML), .ADDR_WIDTH(AW), .NUM_TAPS(NT), .EDGE_MODE(0)) u_zero (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof), .in_eol(in_eol),
    .out_valid(vz), .out_taps(tz), .out_col(cz), .out_eol(ez), .out_full(fz), .ovf_err(oz));

  hdmi_line_window #(.DATA_WIDTH(DW), .MAX_LINE(ML), .ADDR_WIDTH(AW), .NUM_TAPS(NT), .EDGE_MODE(1)) u_repl (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof), .in_eol(in_eol),
    .out_valid(vr), .out_taps(tr), .out_col(cr), .out_eol(er), .out_full(fr), .ovf_err(or_));

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: the current line plus the last two completed lines, newest first.
  int            m_col, m_lf;
  logic [DW-1:0] cur [16];
  logic [DW-1:0] hist [2][16];

  logic           e_v, e_ovf, e_eol, e_full;
  logic [NT*DW-1:0] e_tz, e_tr;
  logic [AW-1:0]  e_col;

  typedef struct {
    logic          sof;
    logic          eol;
    logic [DW-1:0] d;
    logic [23:0]   tz;
    logic [23:0]   tr;
    logic          full;
  } vec_t;
  vec_t tbl [24];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [DW-1:0] mtap(input int k, input int c, input logic [DW-1:0] d, input int mode);
    if (k == 0) return d;
    if (k <= m_lf) return hist[k-1][c];
    if (mode == 0) return '0;
    if (m_lf == 0) return d;
    return hist[m_lf-1][c];
  endfunction

  task automatic model_reset();
    m_col = 0;
    m_lf  = 0;
  endtask

  task automatic step(input logic v, input logic s, input logic e, input logic [DW-1:0] d);
    int  c;
    logic acc;
    @(negedge clk);
    in_valid = v; in_sof = s; in_eol = e; in_data = d;
    e_v = 1'b0; e_ovf = 1'b0;
    if (v) begin
      if (s) model_reset();
      c   = m_col;
      acc = (c < ML);
      e_v = acc;
      e_ovf = !acc;
      if (acc) begin
        e_tz   = {mtap(2, c, d, 0), mtap(1, c, d, 0), d};
        e_tr   = {mtap(2, c, d, 1), mtap(1, c, d, 1), d};
        e_col  = c[AW-1:0];
        e_eol  = e;
        e_full = (m_lf == NT-1);
        cur[c] = d;
      end
      if (e) begin
        for (int i = 0; i < 16; i++) begin
          hist[1][i] = hist[0][i];
          hist[0][i] = cur[i];
        end
        m_col = 0;
        if (m_lf < NT-1) m_lf++;
      end else if (acc) begin
        m_col++;
      end
    end
    @(posedge clk);
    #1;
    chk("valid_z", 64'(vz), 64'(e_v));
    chk("valid_r", 64'(vr), 64'(e_v));
    chk("ovf_z", 64'(oz), 64'(e_ovf));
    chk("ovf_r", 64'(or_), 64'(e_ovf));
    if (e_v) begin
      chk("taps_z", 64'(tz), 64'(e_tz));
      chk("taps_r", 64'(tr), 64'(e_tr));
      chk("side_z", 64'({cz, ez, fz}), 64'({e_col, e_eol, e_full}));
      chk("side_r", 64'({cr, er, fr}), 64'({e_col, e_eol, e_full}));
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  int ovf_cnt;
  logic [DW-1:0] rd;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_z", 64'({vz, tz, cz, ez, fz, oz}), 64'd0);
    chk("reset_r", 64'({vr, tr, cr, er, fr, or_}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Three-line frame, pixel = line*16 + col.
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 8; c++) begin
        tbl[l*8+c].sof  = (l == 0 && c == 0);
        tbl[l*8+c].eol  = (c == 7);
        tbl[l*8+c].d    = 8'(l*16 + c);
        tbl[l*8+c].tz   = {(l >= 2) ? 8'(c) : 8'h00, (l >= 1) ? 8'(16*(l-1) + c) : 8'h00, 8'(l*16 + c)};
        tbl[l*8+c].tr   = {(l == 2) ? 8'(c) : ((l == 1) ? 8'(c) : 8'(c)),
                           (l >= 1) ? 8'(16*(l-1) + c) : 8'(c), 8'(l*16 + c)};
        tbl[l*8+c].full = (l == 2);
      end
    end
    for (int i = 0; i < 24; i++) begin
      step(1'b1, tbl[i].sof, tbl[i].eol, tbl[i].d);
      chk("tbl_taps_z", 64'(tz), 64'(tbl[i].tz));
      chk("tbl_taps_r", 64'(tr), 64'(tbl[i].tr));
      chk("tbl_full", 64'(fz), 64'(tbl[i].full));
      if (i == 19) chk("l2c3_taps", 64'(tz), 64'h031323);
      if (i == 13) chk("l1c5_repl", 64'(tr), 64'h050515);
    end

    // Overflow: a 10-pixel line with MAX_LINE 8, then a normal line.
    ovf_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, c == 0, c == 9, 8'(8'h40 + c));
      if (oz) ovf_cnt++;
      if (c >= 8) chk("ovf_no_valid", 64'(vz), 64'd0);
    end
    chk("ovf_count", 64'(ovf_cnt), 64'd2);
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b0, c == 7, 8'(8'h50 + c));
      if (c == 0) chk("ovf_resume", 64'({cz, tz}), 64'({3'd0, 8'h00, 8'h40, 8'h50}));
    end

    // Mid-line start-of-frame.
    for (int c = 0; c < 8; c++) step(1'b1, c == 0, c == 7, 8'(8'h60 + c));
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b0, 8'(8'h70 + c));
    for (int c = 0; c < 8; c++) begin
      step(1'b1, c == 0, c == 7, 8'(8'h80 + c));
      if (c == 0) begin
        chk("sof_mid_z", 64'({cz, fz, tz}), 64'({3'd0, 1'b0, 8'h00, 8'h00, 8'h80}));
        chk("sof_mid_r", 64'(tr), 64'({8'h80, 8'h80, 8'h80}));
      end
    end
    step(1'b1, 1'b0, 1'b0, 8'h90);
    chk("sof_next_line", 64'(tz), 64'({8'h00, 8'h80, 8'h90}));
    for (int c = 1; c < 8; c++) step(1'b1, 1'b0, c == 7, 8'(8'h90 + c));

    // Single-pixel lines, first one with sof+eol.
    step(1'b1, 1'b1, 1'b1, 8'hA1);
    chk("sp1_full", 64'(fz), 64'd0);
    step(1'b1, 1'b0, 1'b1, 8'hA2);
    chk("sp2_taps", 64'({fz, tz}), 64'({1'b0, 8'h00, 8'hA1, 8'hA2}));
    step(1'b1, 1'b0, 1'b1, 8'hA3);
    chk("sp3_taps", 64'({fz, tz}), 64'({1'b1, 8'hA1, 8'hA2, 8'hA3}));
    step(1'b1, 1'b0, 1'b1, 8'hA4);
    chk("sp4_taps", 64'({fz, tz}), 64'({1'b1, 8'hA2, 8'hA3, 8'hA4}));

    // Asynchronous reset in the middle of a line.
    for (int c = 0; c < 8; c++) step(1'b1, c == 0, c == 7, 8'(8'hB0 + c));
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b0, 8'(8'hC0 + c));
    #2 rst = 1'b1;
    #1;
    chk("arst_z", 64'({vz, tz, cz, ez, fz, oz}), 64'd0);
    chk("arst_r", 64'({vr, tr, cr, er, fr, or_}), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b0, c == 7, 8'(8'hD0 + c));
      if (c == 0) chk("post_rst", 64'({cz, tz, tr}), 64'({3'd0, 8'h00, 8'h00, 8'hD0, 8'hD0, 8'hD0, 8'hD0}));
    end
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0, c == 7, 8'(8'hE0 + c));

    // Random frames of constant line length, with idle gaps, ignored strobes and restarts.
    for (int f = 0; f < 30; f++) begin
      int  len, nl;
      bit  abort;
      len = $urandom_range(1, 10);
      nl  = $urandom_range(1, 5);
      abort = 1'b0;
      for (int l = 0; l < nl && !abort; l++) begin
        for (int c = 0; c < len && !abort; c++) begin
          while ($urandom_range(0, 3) == 0) begin
            rd = 8'($urandom);
            step(1'b0, rd[0], rd[1], rd);
          end
          step(1'b1, (l == 0 && c == 0), (c == len-1), 8'($urandom));
          if ($urandom_range(0, 59) == 0) abort = 1'b1;
        end
      end
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
